// File: rtl/addrc_line_collector.sv
// addrc_line_collector
//   Collects one state (DEPTH lines of LINE_W bits) written by the add-round-constant stage,
//   verifies on the done pulse that every line index was written, then streams the lines out
//   in index order over a valid/ready port.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   write_enable line write strobe from the addRC stage
//   cnt_value    line index of the write
//   write_value  line data of the write
//   donee        one-cycle pulse: source finished the state
//   out_ready    downstream accepts out_line this cycle
//   out_valid    out_line/out_index valid (high while draining)
//   out_line     drained line data (0 when not valid)
//   out_index    index of out_line (0 when not valid)
//   frame_done   one-cycle pulse the cycle after the last line is accepted
//   busy         high while draining
//   err_missing  sticky: donee arrived with an incomplete state
//   err_overrun  sticky: write_enable seen outside collection
module addrc_line_collector #(
  parameter int LINE_W = 25,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] cnt_value,
  input  logic [LINE_W-1:0] write_value,
  input  logic              donee,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_line,
  output logic [ADDR_W-1:0] out_index,
  output logic              frame_done,
  output logic              busy,
  output logic              err_missing,
  output logic              err_overrun
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_ERR     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]    bitmap_q, bitmap_d;
  logic                frame_done_q, frame_done_d;
  logic                err_missing_q, err_missing_d;
  logic                err_overrun_q, err_overrun_d;

  logic [LINE_W-1:0]   line_mem [DEPTH];
  logic [DEPTH-1:0]    wr_mask;
  logic                mem_we;
  logic                last_beat;

  // One-hot decode of the incoming write index; lets the completeness check
  // see a write arriving in the same cycle as donee.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_mask
    assign wr_mask[gi] = write_enable && (cnt_value == ADDR_W'(gi));
  end

  assign mem_we    = write_enable && (state_q == ST_COLLECT);
  assign last_beat = (rd_ptr_q == ADDR_W'(DEPTH - 1));

  // Line storage is never reset; the bitmap alone decides what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      line_mem[cnt_value] <= write_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_COLLECT;
      rd_ptr_q      <= '0;
      bitmap_q      <= '0;
      frame_done_q  <= 1'b0;
      err_missing_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      bitmap_q      <= bitmap_d;
      frame_done_q  <= frame_done_d;
      err_missing_q <= err_missing_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    bitmap_d      = bitmap_q;
    frame_done_d  = 1'b0;
    err_missing_d = err_missing_q;
    err_overrun_d = err_overrun_q;

    case (state_q)
      ST_COLLECT: begin
        bitmap_d = bitmap_q | wr_mask;
        if (donee) begin
          if (&(bitmap_q | wr_mask)) begin
            state_d  = ST_DRAIN;
            rd_ptr_d = '0;
          end else begin
            state_d       = ST_ERR;
            err_missing_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (write_enable) begin
          err_overrun_d = 1'b1;
        end
        if (out_ready) begin
          if (last_beat) begin
            frame_done_d = 1'b1;
            bitmap_d     = '0;
            rd_ptr_d     = '0;
            state_d      = ST_COLLECT;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
      end

      ST_ERR: begin
        // Only reset leaves this state.
        if (write_enable) begin
          err_overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // Read straight from the registered pointer so the beat is visible in the
  // same cycle the pointer settles; outputs are forced to zero when idle.
  assign out_valid   = (state_q == ST_DRAIN);
  assign busy        = (state_q == ST_DRAIN);
  assign out_index   = out_valid ? rd_ptr_q : '0;
  assign out_line    = out_valid ? line_mem[rd_ptr_q] : '0;
  assign frame_done  = frame_done_q;
  assign err_missing = err_missing_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_addrc_line_collector.sv
module tb_addrc_line_collector;

  localparam int LINE_W = 25;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DRAIN_BUDGET = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic              write_enable;
  logic [ADDR_W-1:0] cnt_value;
  logic [LINE_W-1:0] write_value;
  logic              donee;
  logic              out_ready;
  logic              out_valid;
  logic [LINE_W-1:0] out_line;
  logic [ADDR_W-1:0] out_index;
  logic              frame_done;
  logic              busy;
  logic              err_missing;
  logic              err_overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the state as the source intends it, index -> line.
  logic [LINE_W-1:0] ref_mem [DEPTH];

  // Observations of one drain, filled by drain_collect.
  int                obs_idx  [$];
  logic [LINE_W-1:0] obs_line [$];
  int                fd_count;
  int                fd_cyc;
  int                last_beat_cyc;
  int                hold_err;
  bit                fd_with_valid;
  bit                timed_out;

  always #5 clk = ~clk;

  addrc_line_collector #(
    .LINE_W(LINE_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_enable(write_enable),
    .cnt_value   (cnt_value),
    .write_value (write_value),
    .donee       (donee),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_line    (out_line),
    .out_index   (out_index),
    .frame_done  (frame_done),
    .busy        (busy),
    .err_missing (err_missing),
    .err_overrun (err_overrun)
  );

  // ---------------- stimulus helpers (drive only, no checking) ----------------

  task automatic do_write(input int idx, input logic [LINE_W-1:0] val, input bit with_done);
    write_enable = 1'b1;
    cnt_value    = ADDR_W'(idx);
    write_value  = val;
    donee        = with_done;
    @(negedge clk);
    write_enable = 1'b0;
    donee        = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic pulse_done();
    donee = 1'b1;
    @(negedge clk);
    donee = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Writes every index except skip_idx in a random order with random data.
  // If done_with_last is set, donee rides along with the final write.
  task automatic fill_random(input int skip_idx, input bit done_with_last);
    int order [DEPTH];
    int n;
    int last;
    for (int i = 0; i < DEPTH; i++) order[i] = i;
    for (int i = DEPTH - 1; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    n = 0;
    last = -1;
    for (int i = 0; i < DEPTH; i++) if (order[i] != skip_idx) last = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (order[i] == skip_idx) continue;
      do_write(order[i], LINE_W'($urandom), done_with_last && (i == last));
      n++;
    end
    if (!done_with_last) pulse_done();
  endtask

  // Runs the output side until frame_done (or budget), recording accepted beats.
  // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; mode 2: random.
  // inj_cycle >= 0 fires one write_enable at that drain cycle.
  task automatic drain_collect(input int mode, input int inj_cycle, input int inj_idx,
                               input logic [LINE_W-1:0] inj_val);
    bit                r;
    bit                prev_stall;
    logic [ADDR_W-1:0] prev_i;
    logic [LINE_W-1:0] prev_l;
    int                cyc;
    obs_idx.delete();
    obs_line.delete();
    fd_count      = 0;
    fd_cyc        = -1;
    last_beat_cyc = -1;
    hold_err      = 0;
    fd_with_valid = 1'b0;
    timed_out     = 1'b0;
    prev_stall    = 1'b0;
    prev_i        = '0;
    prev_l        = '0;
    cyc           = 0;
    while (fd_count == 0 && cyc < DRAIN_BUDGET) begin
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
        if (out_valid) fd_with_valid = 1'b1;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall && out_valid && (out_index !== prev_i || out_line !== prev_l)) hold_err++;
      out_ready = r;
      if (cyc == inj_cycle) begin
        write_enable = 1'b1;
        cnt_value    = ADDR_W'(inj_idx);
        write_value  = inj_val;
      end else begin
        write_enable = 1'b0;
      end
      if (out_valid && r) begin
        obs_idx.push_back(int'(out_index));
        obs_line.push_back(out_line);
        last_beat_cyc = cyc;
      end
      prev_stall = out_valid && !r;
      prev_i     = out_index;
      prev_l     = out_line;
      @(negedge clk);
      cyc++;
    end
    out_ready    = 1'b0;
    write_enable = 1'b0;
    if (fd_count == 0) timed_out = 1'b1;
    // One more cycle: frame_done must have been a single pulse.
    if (frame_done) fd_count++;
    $display("[TB] drain mode %0d: %0d beats, frame_done at cycle %0d, last beat at cycle %0d",
             mode, obs_idx.size(), fd_cyc, last_beat_cyc);
  endtask

  // ---------------- test scenarios ----------------

  task automatic test_reset();
    rst = 1'b1; write_enable = 1'b0; cnt_value = '0; write_value = '0;
    donee = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    tests_run++;
    if ({err_missing, err_overrun} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_flags: got %b%b expected 00", err_missing, err_overrun);
    end
    tests_run++;
    if (out_index !== '0 || out_line !== '0) begin
      tests_failed++; $display("FAIL reset_out_data: got idx %0d line %h expected 0 0", out_index, out_line);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] test_reset done");
  endtask

  task automatic test_sequential_frame();
    for (int i = 0; i < DEPTH; i++) do_write(i, LINE_W'(i * 3), 1'b0);
    pulse_done();
    tests_run++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL seq_valid_latency: got valid %b busy %b expected 1 1", out_valid, busy);
    end
    drain_collect(0, -1, 0, '0);
    tests_run++;
    if (obs_idx.size() != DEPTH) begin
      tests_failed++; $display("FAIL seq_beat_count: got %0d expected %0d", obs_idx.size(), DEPTH);
    end
    for (int i = 0; i < obs_idx.size() && i < DEPTH; i++) begin
      tests_run++;
      if (obs_idx[i] != i || obs_line[i] !== LINE_W'(i * 3)) begin
        tests_failed++;
        $display("FAIL seq_beat: beat %0d got idx %0d line %h expected idx %0d line %h",
                 i, obs_idx[i], obs_line[i], i, LINE_W'(i * 3));
      end
    end
    tests_run++;
    if (timed_out || fd_count != 1 || fd_cyc != last_beat_cyc + 1 || fd_with_valid) begin
      tests_failed++;
      $display("FAIL seq_frame_done: got count %0d at cycle %0d valid %b expected 1 pulse at cycle %0d valid 0",
               fd_count, fd_cyc, fd_with_valid, last_beat_cyc + 1);
    end
    tests_run++;
    if ({err_missing, err_overrun, out_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL seq_after_frame: got miss %b ovr %b valid %b expected 000", err_missing, err_overrun, out_valid);
    end
  endtask

  task automatic test_reverse_duplicate();
    do_write(5, 25'h0000001, 1'b0);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i == 5) do_write(i, 25'h1ABCDEF, 1'b0);
      else        do_write(i, LINE_W'($urandom), 1'b0);
    end
    pulse_done();
    drain_collect(2, -1, 0, '0);
    tests_run++;
    if (obs_idx.size() != DEPTH || timed_out) begin
      tests_failed++; $display("FAIL rev_beat_count: got %0d expected %0d", obs_idx.size(), DEPTH);
    end
    tests_run++;
    if (obs_line.size() > 5 && obs_line[5] !== 25'h1ABCDEF) begin
      tests_failed++; $display("FAIL rev_dup_last_wins: got %h expected 1abcdef", obs_line[5]);
    end
    for (int i = 0; i < obs_idx.size() && i < DEPTH; i++) begin
      tests_run++;
      if (obs_idx[i] != i || obs_line[i] !== ref_mem[i]) begin
        tests_failed++;
        $display("FAIL rev_beat: beat %0d got idx %0d line %h expected idx %0d line %h",
                 i, obs_idx[i], obs_line[i], i, ref_mem[i]);
      end
    end
    tests_run++;
    if (err_missing !== 1'b0 || err_overrun !== 1'b0) begin
      tests_failed++; $display("FAIL rev_no_error: got miss %b ovr %b expected 0 0", err_missing, err_overrun);
    end
  endtask

  task automatic test_missing_line();
    int bad;
    fill_random(40, 1'b0);
    tests_run++;
    if (err_missing !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss_flag: got miss %b valid %b busy %b expected 1 0 0", err_missing, out_valid, busy);
    end
    // Late donee and idle cycles must not start a drain.
    bad = 0;
    pulse_done();
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0 || err_missing !== 1'b1 || frame_done !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL miss_stays_err: got %0d bad cycles expected 0", bad); end
    apply_reset();
    tests_run++;
    if (err_missing !== 1'b0) begin tests_failed++; $display("FAIL miss_cleared_by_rst: got %b expected 0", err_missing); end
    fill_random(-1, 1'b0);
    drain_collect(0, -1, 0, '0);
    bad = 0;
    for (int i = 0; i < obs_idx.size(); i++) if (obs_idx[i] != i || obs_line[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0 || obs_idx.size() != DEPTH || fd_count != 1) begin
      tests_failed++;
      $display("FAIL miss_recover_frame: got %0d beats %0d bad %0d frame_done expected %0d 0 1",
               obs_idx.size(), bad, fd_count, DEPTH);
    end
  endtask

  task automatic test_done_with_last();
    int bad;
    for (int i = 0; i < DEPTH - 1; i++) do_write(i, LINE_W'($urandom), 1'b0);
    do_write(DEPTH - 1, LINE_W'($urandom), 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || err_missing !== 1'b0) begin
      tests_failed++;
      $display("FAIL last_with_done: got valid %b miss %b expected 1 0", out_valid, err_missing);
    end
    drain_collect(2, -1, 0, '0);
    bad = 0;
    for (int i = 0; i < obs_idx.size(); i++) if (obs_idx[i] != i || obs_line[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0 || obs_idx.size() != DEPTH) begin
      tests_failed++;
      $display("FAIL last_with_done_data: got %0d beats %0d bad expected %0d 0", obs_idx.size(), bad, DEPTH);
    end
  endtask

  task automatic test_stall_overrun();
    int inj_idx;
    int bad;
    inj_idx = $urandom_range(0, DEPTH - 1);
    fill_random(-1, 1'b0);
    drain_collect(1, 7, inj_idx, ~ref_mem[inj_idx]);
    tests_run++;
    if (hold_err != 0) begin tests_failed++; $display("FAIL stall_hold: got %0d changes expected 0", hold_err); end
    tests_run++;
    if (obs_idx.size() != DEPTH || timed_out) begin
      tests_failed++; $display("FAIL stall_beat_count: got %0d expected %0d", obs_idx.size(), DEPTH);
    end
    bad = 0;
    for (int i = 0; i < obs_idx.size(); i++) if (obs_idx[i] != i || obs_line[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL stall_data: got %0d bad beats expected 0", bad); end
    tests_run++;
    if (err_overrun !== 1'b1 || err_missing !== 1'b0) begin
      tests_failed++; $display("FAIL stall_overrun_flag: got ovr %b miss %b expected 1 0", err_overrun, err_missing);
    end
  endtask

  // After a completed frame the written-bitmap must start empty again.
  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH / 2; i++) do_write(i, LINE_W'($urandom), 1'b0);
    pulse_done();
    tests_run++;
    if (err_missing !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_bitmap_cleared: got miss %b valid %b expected 1 0", err_missing, out_valid);
    end
    tests_run++;
    if (err_overrun !== 1'b1) begin tests_failed++; $display("FAIL b2b_overrun_sticky: got %b expected 1", err_overrun); end
    apply_reset();
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    int bad;
    fill_random(-1, 1'b0);
    cyc = 0;
    out_ready = 1'b1;
    while (!(out_valid && out_index == ADDR_W'(20)) && cyc < DRAIN_BUDGET) begin
      if (out_valid && out_index == ADDR_W'(10)) begin
        write_enable = 1'b1; cnt_value = '0; write_value = '1;
      end else begin
        write_enable = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    write_enable = 1'b0;
    tests_run++;
    if (cyc >= DRAIN_BUDGET || err_overrun !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_reach_beat20: got cycles %0d ovr %b expected <%0d 1", cyc, err_overrun, DRAIN_BUDGET);
    end
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({out_valid, busy, frame_done, err_missing, err_overrun} !== 5'b0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got valid %b busy %b fd %b miss %b ovr %b expected all 0",
               out_valid, busy, frame_done, err_missing, err_overrun);
    end
    rst = 1'b0;
    @(negedge clk);
    fill_random(-1, 1'b0);
    drain_collect(2, -1, 0, '0);
    bad = 0;
    for (int i = 0; i < obs_idx.size(); i++) if (obs_idx[i] != i || obs_line[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0 || obs_idx.size() != DEPTH || fd_count != 1) begin
      tests_failed++;
      $display("FAIL rstmid_new_frame: got %0d beats %0d bad %0d frame_done expected %0d 0 1",
               obs_idx.size(), bad, fd_count, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_sequential_frame();
    test_reverse_duplicate();
    test_missing_line();
    test_done_with_last();
    test_stall_overrun();
    test_back_to_back();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
